// File: rtl/rs_operand_wakeup.sv
// rtl/rs_operand_wakeup.sv - reservation station entry array with operand wakeup and issue select
// Optional feature macro: RS_OLDEST_FIRST_EN (age-based oldest-first issue selection)
module rs_operand_wakeup #(
    parameter int DEPTH       = 8,
    parameter int DEPTH_SEL   = 3,
    parameter int DATA_LEN    = 32,
    parameter int RRF_SEL     = 6,
    parameter int PAYLOAD_LEN = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   disp_valid,
    output logic                   disp_ready,
    input  logic [DATA_LEN-1:0]    disp_opr1,
    input  logic                   disp_rdy1,
    input  logic [DATA_LEN-1:0]    disp_opr2,
    input  logic                   disp_rdy2,
    input  logic [PAYLOAD_LEN-1:0] disp_payload,
    input  logic [DATA_LEN-1:0]    exrslt1,
    input  logic [RRF_SEL-1:0]     exdst1,
    input  logic                   kill_spec1,
    input  logic [DATA_LEN-1:0]    exrslt2,
    input  logic [RRF_SEL-1:0]     exdst2,
    input  logic                   kill_spec2,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [DATA_LEN-1:0]    issue_src1,
    output logic [DATA_LEN-1:0]    issue_src2,
    output logic [PAYLOAD_LEN-1:0] issue_payload,
    output logic [DEPTH_SEL:0]     count
);

    logic [DEPTH-1:0]       busy, rdy1, rdy2, cand;
    logic [DATA_LEN-1:0]    opr1    [DEPTH];
    logic [DATA_LEN-1:0]    opr2    [DEPTH];
    logic [PAYLOAD_LEN-1:0] payload [DEPTH];
    logic [DATA_LEN:0]      wk1 [DEPTH];
    logic [DATA_LEN:0]      wk2 [DEPTH];
    logic [DATA_LEN:0]      dk1, dk2;
    logic                   locked, pick_found;
    logic [DEPTH_SEL-1:0]   lock_idx, pick_idx, sel_idx, free_idx;
    logic                   disp_fire, issue_fire;
`ifdef RS_OLDEST_FIRST_EN
    logic [DEPTH_SEL-1:0]   age [DEPTH];
`endif

    // Result-bus snoop: MSB flags a hit, low bits carry the value; bus 1 overrides bus 2
    function automatic logic [DATA_LEN:0] snoop(
        input logic [RRF_SEL-1:0]  tag,
        input logic                k1,
        input logic [RRF_SEL-1:0]  d1,
        input logic [DATA_LEN-1:0] r1,
        input logic                k2,
        input logic [RRF_SEL-1:0]  d2,
        input logic [DATA_LEN-1:0] r2
    );
        logic [DATA_LEN:0] res;
        res = '0;
        if (!k2 && d2 == tag) res = {1'b1, r2};
        if (!k1 && d1 == tag) res = {1'b1, r1};
        return res;
    endfunction

    // Tag compares for the incoming instruction and for every stored operand
    always_comb begin
        dk1 = snoop(disp_opr1[RRF_SEL-1:0], kill_spec1, exdst1, exrslt1, kill_spec2, exdst2, exrslt2);
        dk2 = snoop(disp_opr2[RRF_SEL-1:0], kill_spec1, exdst1, exrslt1, kill_spec2, exdst2, exrslt2);
        for (int i = 0; i < DEPTH; i++) begin
            wk1[i] = snoop(opr1[i][RRF_SEL-1:0], kill_spec1, exdst1, exrslt1, kill_spec2, exdst2, exrslt2);
            wk2[i] = snoop(opr2[i][RRF_SEL-1:0], kill_spec1, exdst1, exrslt1, kill_spec2, exdst2, exrslt2);
        end
    end

    // Lowest-index free entry receives the next dispatch
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) free_idx = DEPTH_SEL'(i);
        end
    end

    assign cand       = busy & rdy1 & rdy2;
    assign disp_ready = ~&busy;
    assign disp_fire  = disp_valid & disp_ready;
    assign issue_valid = |cand;
    assign issue_fire = issue_valid & issue_ready;

    // Issue pick; a stalled selection stays locked so the presented entry never changes under backpressure
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
`ifdef RS_OLDEST_FIRST_EN
            if (cand[i] && (!pick_found || age[i] > age[pick_idx])) begin
`else
            if (cand[i] && !pick_found) begin
`endif
                pick_idx   = DEPTH_SEL'(i);
                pick_found = 1'b1;
            end
        end
        sel_idx = locked ? lock_idx : pick_idx;
    end

    assign issue_src1    = issue_valid ? opr1[sel_idx]    : '0;
    assign issue_src2    = issue_valid ? opr2[sel_idx]    : '0;
    assign issue_payload = issue_valid ? payload[sel_idx] : '0;

    // Entry state: allocate on dispatch (with bypass), capture wakeups, free on issue or flush
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
            rdy1 <= '0;
            rdy2 <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                opr1[i]    <= '0;
                opr2[i]    <= '0;
                payload[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (flush) begin
                    busy[i] <= 1'b0;
                end else if (disp_fire && free_idx == DEPTH_SEL'(i)) begin
                    busy[i]    <= 1'b1;
                    payload[i] <= disp_payload;
                    rdy1[i]    <= disp_rdy1 | dk1[DATA_LEN];
                    rdy2[i]    <= disp_rdy2 | dk2[DATA_LEN];
                    opr1[i]    <= (!disp_rdy1 && dk1[DATA_LEN]) ? dk1[DATA_LEN-1:0] : disp_opr1;
                    opr2[i]    <= (!disp_rdy2 && dk2[DATA_LEN]) ? dk2[DATA_LEN-1:0] : disp_opr2;
                end else begin
                    if (issue_fire && sel_idx == DEPTH_SEL'(i)) busy[i] <= 1'b0;
                    if (busy[i] && !rdy1[i] && wk1[i][DATA_LEN]) begin
                        opr1[i] <= wk1[i][DATA_LEN-1:0];
                        rdy1[i] <= 1'b1;
                    end
                    if (busy[i] && !rdy2[i] && wk2[i][DATA_LEN]) begin
                        opr2[i] <= wk2[i][DATA_LEN-1:0];
                        rdy2[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Occupancy count and issue-selection lock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            locked   <= 1'b0;
            lock_idx <= '0;
        end else if (flush) begin
            count    <= '0;
            locked   <= 1'b0;
            lock_idx <= '0;
        end else begin
            count    <= count + (DEPTH_SEL+1)'(disp_fire) - (DEPTH_SEL+1)'(issue_fire);
            locked   <= issue_valid & ~issue_ready;
            lock_idx <= sel_idx;
        end
    end

`ifdef RS_OLDEST_FIRST_EN
    // Age tracking: new entry starts at 0, every other busy entry ages on each dispatch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) age[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) age[i] <= '0;
        end else if (disp_fire) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (free_idx == DEPTH_SEL'(i))
                    age[i] <= '0;
                else if (busy[i] && age[i] != DEPTH_SEL'(DEPTH - 1))
                    age[i] <= age[i] + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rs_operand_wakeup.sv
// tb/tb_rs_operand_wakeup.sv - directed vector bench for rs_operand_wakeup
module tb_rs_operand_wakeup;

    logic        clk = 1'b0;
    logic        reset_n, flush, disp_valid, disp_ready, disp_rdy1, disp_rdy2;
    logic [31:0] disp_opr1, disp_opr2, disp_payload;
    logic [31:0] exrslt1, exrslt2;
    logic [5:0]  exdst1, exdst2;
    logic        kill_spec1, kill_spec2;
    logic        issue_valid, issue_ready;
    logic [31:0] issue_src1, issue_src2, issue_payload;
    logic [3:0]  count;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        fl, dv, r1, r2, ir;
        logic [31:0] o1, o2, pl;
        logic        k1, k2;
        logic [5:0]  d1, d2;
        logic [31:0] x1, x2;
        logic        e_iv, e_dr;
        logic [31:0] e_s1, e_s2, e_pl;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t vt [18];

    rs_operand_wakeup dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_opr1(disp_opr1), .disp_rdy1(disp_rdy1),
        .disp_opr2(disp_opr2), .disp_rdy2(disp_rdy2),
        .disp_payload(disp_payload),
        .exrslt1(exrslt1), .exdst1(exdst1), .kill_spec1(kill_spec1),
        .exrslt2(exrslt2), .exdst2(exdst2), .kill_spec2(kill_spec2),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_src1(issue_src1), .issue_src2(issue_src2),
        .issue_payload(issue_payload), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic iv, input logic [31:0] s1,
                           input logic [31:0] s2, input logic [31:0] pl,
                           input logic [3:0] cnt, input logic dr);
        chk({tag, ".issue_valid"}, 32'(issue_valid), 32'(iv));
        chk({tag, ".count"}, 32'(count), 32'(cnt));
        chk({tag, ".disp_ready"}, 32'(disp_ready), 32'(dr));
        if (iv) begin
            chk({tag, ".issue_src1"}, issue_src1, s1);
            chk({tag, ".issue_src2"}, issue_src2, s2);
            chk({tag, ".issue_payload"}, issue_payload, pl);
        end
    endtask

    function automatic vec_t mk(input logic dv, input logic [31:0] o1, input logic r1,
                                input logic [31:0] o2, input logic r2, input logic [31:0] pl,
                                input logic ir, input logic e_iv, input logic [31:0] e_s1,
                                input logic [31:0] e_s2, input logic [31:0] e_pl,
                                input logic [3:0] e_cnt);
        vec_t v;
        v.fl = 1'b0; v.dv = dv; v.o1 = o1; v.r1 = r1; v.o2 = o2; v.r2 = r2; v.pl = pl;
        v.ir = ir;
        v.k1 = 1'b1; v.d1 = '0; v.x1 = '0;
        v.k2 = 1'b1; v.d2 = '0; v.x2 = '0;
        v.e_iv = e_iv; v.e_s1 = e_s1; v.e_s2 = e_s2; v.e_pl = e_pl;
        v.e_cnt = e_cnt; v.e_dr = 1'b1;
        return v;
    endfunction

    function automatic vec_t b1(input vec_t vi, input logic [5:0] d, input logic [31:0] x);
        vec_t v;
        v = vi; v.k1 = 1'b0; v.d1 = d; v.x1 = x;
        return v;
    endfunction

    function automatic vec_t b2(input vec_t vi, input logic [5:0] d, input logic [31:0] x);
        vec_t v;
        v = vi; v.k2 = 1'b0; v.d2 = d; v.x2 = x;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        flush = v.fl; disp_valid = v.dv;
        disp_opr1 = v.o1; disp_rdy1 = v.r1; disp_opr2 = v.o2; disp_rdy2 = v.r2;
        disp_payload = v.pl; issue_ready = v.ir;
        kill_spec1 = v.k1; exdst1 = v.d1; exrslt1 = v.x1;
        kill_spec2 = v.k2; exdst2 = v.d2; exrslt2 = v.x2;
    endtask

    task automatic idle();
        flush = 1'b0; disp_valid = 1'b0; issue_ready = 1'b0;
        disp_opr1 = '0; disp_rdy1 = 1'b0; disp_opr2 = '0; disp_rdy2 = 1'b0; disp_payload = '0;
        kill_spec1 = 1'b1; exdst1 = '0; exrslt1 = '0;
        kill_spec2 = 1'b1; exdst2 = '0; exrslt2 = '0;
    endtask

    task automatic disp(input logic [31:0] o1, input logic r1, input logic [31:0] o2,
                        input logic r2, input logic [31:0] pl);
        disp_valid = 1'b1; disp_opr1 = o1; disp_rdy1 = r1;
        disp_opr2 = o2; disp_rdy2 = r2; disp_payload = pl;
    endtask

    initial begin
        // wakeup, bypass, kill and priority vectors; outputs are checked before the edge
        vt[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[1]  = mk(1, 32'h11, 1, 32'hF05, 0, 32'hA1, 0, 0, 0, 0, 0, 0);
        vt[2]  = b1(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 6'd5, 32'hAB);
        vt[3]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h11, 32'hAB, 32'hA1, 1);
        vt[4]  = b2(mk(1, 32'h22, 1, 32'd7, 0, 32'hA2, 0, 0, 0, 0, 0, 0), 6'd7, 32'h55);
        vt[5]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h22, 32'h55, 32'hA2, 1);
        vt[6]  = mk(1, 32'h33, 1, 32'd7, 0, 32'hA3, 1, 0, 0, 0, 0, 0);
        vt[6].d2 = 6'd7; vt[6].x2 = 32'h66;
        vt[7]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        vt[8]  = b2(b1(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1), 6'd7, 32'h77), 6'd7, 32'h88);
        vt[9]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h33, 32'h77, 32'hA3, 1);
        vt[10] = b2(mk(1, 32'd9, 0, 32'h44, 1, 32'hA4, 0, 0, 0, 0, 0, 0), 6'd9, 32'h88);
        vt[10].d1 = 6'd9; vt[10].x1 = 32'h99;
        vt[11] = mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h88, 32'h44, 32'hA4, 1);
        vt[12] = b2(b1(mk(1, 32'd3, 0, 32'd3, 0, 32'hA5, 0, 0, 0, 0, 0, 0), 6'd3, 32'h31), 6'd3, 32'h32);
        vt[13] = mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h31, 32'h31, 32'hA5, 1);
        vt[14] = b1(mk(1, 32'h05, 1, 32'h2A, 0, 32'hA6, 0, 0, 0, 0, 0, 0), 6'd5, 32'hEE);
        vt[15] = b2(b1(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 6'h2A, 32'h5A), 6'd5, 32'hDD);
        vt[16] = mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h05, 32'h5A, 32'hA6, 1);
        vt[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        reset_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        #1 chk_out("reset", 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(vt[i]);
            #1 chk_out($sformatf("v%0d", i), vt[i].e_iv, vt[i].e_s1, vt[i].e_s2,
                       vt[i].e_pl, vt[i].e_cnt, vt[i].e_dr);
        end

        // full array: freed-by-issue entry is not reusable in the same cycle
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            idle();
            disp(32'(k), 1, 32'h100 + 32'(k), 1, 32'hB0 + 32'(k));
        end
        @(negedge clk);
        idle();
        #1 chk_out("full", 1, 32'd0, 32'h100, 32'hB0, 8, 0);
        @(negedge clk);
        disp(32'hC0, 1, 32'hC1, 1, 32'hC0);
        issue_ready = 1'b1;
        #1 chk_out("full_iss", 1, 32'd0, 32'h100, 32'hB0, 8, 0);
        @(negedge clk);
        issue_ready = 1'b0;
        #1 chk_out("full_retry", 1, 32'd1, 32'h101, 32'hB1, 7, 1);
        @(negedge clk);
        disp_valid = 1'b0;
        #1 chk_out("full_again", 1, 32'd1, 32'h101, 32'hB1, 8, 0);
        @(negedge clk);
        flush = 1'b1; disp_valid = 1'b1; issue_ready = 1'b1;
        #1 chk("flush8.issue_valid", 32'(issue_valid), 32'd1);
        @(negedge clk);
        idle();
        #1 chk_out("flush8_after", 0, 0, 0, 0, 0, 1);

        // four entries then flush with dispatch and issue requested
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            idle();
            disp(32'(k), 1, 32'(k), 1, 32'hE0 + 32'(k));
        end
        @(negedge clk);
        idle();
        #1 chk_out("four", 1, 32'd0, 32'd0, 32'hE0, 4, 1);
        flush = 1'b1; issue_ready = 1'b1;
        disp(32'h9, 1, 32'h9, 1, 32'hEE);
        @(negedge clk);
        idle();
        #1 chk_out("flush4_after", 0, 0, 0, 0, 0, 1);

        // stalled issue holds its entry while lower-index entries wake up
        @(negedge clk);
        idle(); disp(32'd1, 1, 32'd10, 0, 32'hD0);
        @(negedge clk);
        idle(); disp(32'd2, 1, 32'd11, 0, 32'hD1);
        @(negedge clk);
        idle(); disp(32'd3, 1, 32'h33, 1, 32'hD2);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            idle();
            if (c == 1) begin kill_spec1 = 1'b0; exdst1 = 6'd10; exrslt1 = 32'h10A; end
            if (c == 2) begin kill_spec2 = 1'b0; exdst2 = 6'd11; exrslt2 = 32'h10B; end
            #1 chk_out($sformatf("hold%0d", c), 1, 32'd3, 32'h33, 32'hD2, 3, 1);
        end
        @(negedge clk);
        idle(); issue_ready = 1'b1;
        #1 chk_out("drain0", 1, 32'd3, 32'h33, 32'hD2, 3, 1);
        @(negedge clk);
        #1 chk_out("drain1", 1, 32'd1, 32'h10A, 32'hD0, 2, 1);
        @(negedge clk);
        #1 chk_out("drain2", 1, 32'd2, 32'h10B, 32'hD1, 1, 1);
        @(negedge clk);
        issue_ready = 1'b0;
        #1 chk_out("drain3", 0, 0, 0, 0, 0, 1);

        // asynchronous reset between edges
        @(negedge clk);
        idle(); disp(32'h5, 1, 32'h6, 1, 32'hF0);
        @(negedge clk);
        idle(); disp(32'h7, 1, 32'h8, 1, 32'hF1);
        @(negedge clk);
        idle();
        #1 chk_out("pre_rst", 1, 32'h5, 32'h6, 32'hF0, 2, 1);
        #1 reset_n = 1'b0;
        #1 chk_out("async_rst", 0, 0, 0, 0, 0, 1);
        chk("async_rst.issue_src1", issue_src1, 32'd0);
        chk("async_rst.issue_payload", issue_payload, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1 chk_out("post_rst", 0, 0, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
